// File: rtl/bp_ctrl_if.sv
// Fetch/execute-side bundle for the branch-prediction controller.
// The requesters use the master view; the controller uses the slave view.
interface bp_ctrl_if;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        lookup_ready;
  logic        predict_valid;
  logic        predict_taken;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic        update_ready;
  logic        init_busy;

  modport master (
    output lookup_valid, lookup_pc, update_valid, update_pc, update_taken,
    input  lookup_ready, predict_valid, predict_taken, update_ready, init_busy
  );

  modport slave (
    input  lookup_valid, lookup_pc, update_valid, update_pc, update_taken,
    output lookup_ready, predict_valid, predict_taken, update_ready, init_busy
  );
endinterface

// File: rtl/bp_ctrl.sv
// Branch-prediction controller: 2-bit counter BHT shared between fetch lookups and
// FIFO-buffered execute updates, with a starvation guard and a post-reset init sweep.
//
// state  | meaning
// S_INIT | sweeping every BHT entry to weakly not-taken; all traffic ignored
// S_RUN  | lookups have priority; queued updates drain in idle or forced cycles
module bp_ctrl #(
  parameter int IDX_W      = 6,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic      clk,
  input  logic      rst,
  bp_ctrl_if.slave  bus
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int PW      = $clog2(QDEPTH);
  localparam int CW      = PW + 1;
  localparam int SW      = $clog2(STARVE_MAX + 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t state, state_next;

  logic [IDX_W-1:0] init_idx;
  logic [1:0]       bht [ENTRIES];

  logic [IDX_W-1:0] fifo_idx   [QDEPTH];
  logic             fifo_taken [QDEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve;

  logic             empty, full, force_pop;
  logic             lookup_fire, push, pop;
  logic [IDX_W-1:0] lookup_idx, update_idx, head_idx;
  logic             head_taken;
  logic [1:0]       head_ctr, head_ctr_next;
  logic             unused_pc_bits;

  assign lookup_idx = bus.lookup_pc[IDX_W+1:2];
  assign update_idx = bus.update_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.lookup_pc[31:IDX_W+2], bus.lookup_pc[1:0],
                            bus.update_pc[31:IDX_W+2], bus.update_pc[1:0]};

  assign empty = (count == '0);
  assign full  = (count == CW'(QDEPTH));

  assign head_idx   = fifo_idx[rd_ptr];
  assign head_taken = fifo_taken[rd_ptr];
  assign head_ctr   = bht[head_idx];

  always_comb begin
    head_ctr_next = head_ctr;
    if (head_taken) begin
      if (head_ctr != 2'b11) head_ctr_next = head_ctr + 2'b01;
    end else begin
      if (head_ctr != 2'b00) head_ctr_next = head_ctr - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next       = state;
    bus.init_busy    = 1'b0;
    bus.lookup_ready = 1'b0;
    bus.update_ready = 1'b0;
    force_pop        = 1'b0;
    lookup_fire      = 1'b0;
    push             = 1'b0;
    pop              = 1'b0;
    case (state)
      S_INIT: begin
        bus.init_busy = 1'b1;
        if (init_idx == {IDX_W{1'b1}}) state_next = S_RUN;
      end
      S_RUN: begin
        force_pop        = (starve == SW'(STARVE_MAX)) && !empty;
        bus.lookup_ready = !force_pop;
        // Full blocks the push even when a pop frees a slot this cycle.
        bus.update_ready = !full;
        lookup_fire      = bus.lookup_valid && !force_pop;
        push             = bus.update_valid && !full;
        pop              = !empty && (force_pop || !bus.lookup_valid);
      end
      default: state_next = S_INIT;
    endcase
  end

  // Table holds no reset: the sweep defines its contents before any access.
  always_ff @(posedge clk) begin
    if (state == S_INIT) bht[init_idx] <= 2'b01;
    else if (pop)        bht[head_idx] <= head_ctr_next;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr]   <= update_idx;
      fifo_taken[wr_ptr] <= bus.update_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_idx          <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      starve            <= '0;
      bus.predict_valid <= 1'b0;
      bus.predict_taken <= 1'b0;
    end else begin
      if (state == S_INIT) init_idx <= init_idx + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pop || empty) starve <= '0;
      else              starve <= starve + SW'(1);
      bus.predict_valid <= lookup_fire;
      if (lookup_fire) bus.predict_taken <= bht[lookup_idx][1];
    end
  end

endmodule

// File: tb/tb_bp_ctrl.sv
// Directed bench for bp_ctrl: init sweep, counter saturation, aliasing,
// backpressure with forced pop, mid-operation reset and read-after-update.
module tb_bp_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  bp_ctrl_if bus ();

  bp_ctrl #(.IDX_W(6), .QDEPTH(4), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc, output logic rdy,
                        output logic pv, output logic pt);
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = pc;
    #1;
    rdy = bus.lookup_ready;
    @(posedge clk);
    #1;
    bus.lookup_valid = 1'b0;
    pv = bus.predict_valid;
    pt = bus.predict_taken;
  endtask

  // Push at the first edge, pop at the second (fetch idle).
  task automatic update(input logic [31:0] pc, input logic taken);
    bus.update_valid = 1'b1;
    bus.update_pc    = pc;
    bus.update_taken = taken;
    step();
    bus.update_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    int   cnt;
    logic seen_pv, seen_ur, rdy, pv, pt;
    rst = 1'b1;
    bus.lookup_valid = 1'b0; bus.lookup_pc = '0;
    bus.update_valid = 1'b0; bus.update_pc = '0; bus.update_taken = 1'b0;
    step(); step();
    n_total++; if (bus.predict_valid !== 1'b0) $display("FAIL rst_pv: got %b want 0", bus.predict_valid); else n_pass++;
    n_total++; if (bus.predict_taken !== 1'b0) $display("FAIL rst_pt: got %b want 0", bus.predict_taken); else n_pass++;
    n_total++; if (bus.init_busy !== 1'b1) $display("FAIL rst_busy: got %b want 1", bus.init_busy); else n_pass++;
    n_total++; if (bus.lookup_ready !== 1'b0) $display("FAIL rst_lr: got %b want 0", bus.lookup_ready); else n_pass++;
    n_total++; if (bus.update_ready !== 1'b0) $display("FAIL rst_ur: got %b want 0", bus.update_ready); else n_pass++;
    // Traffic during the sweep must be ignored.
    bus.lookup_valid = 1'b1; bus.lookup_pc = 32'h40;
    bus.update_valid = 1'b1; bus.update_pc = 32'h40; bus.update_taken = 1'b1;
    rst = 1'b0;
    cnt = 0; seen_pv = 1'b0; seen_ur = 1'b0;
    while (bus.init_busy === 1'b1 && cnt < 200) begin
      if (bus.predict_valid !== 1'b0) seen_pv = 1'b1;
      if (bus.update_ready !== 1'b0)  seen_ur = 1'b1;
      cnt++;
      step();
    end
    bus.lookup_valid = 1'b0; bus.update_valid = 1'b0;
    n_total++; if (cnt !== 64) $display("FAIL init_len: got %0d want 64", cnt); else n_pass++;
    n_total++; if (seen_pv !== 1'b0) $display("FAIL init_no_predict: got %b want 0", seen_pv); else n_pass++;
    n_total++; if (seen_ur !== 1'b0) $display("FAIL init_no_ready: got %b want 0", seen_ur); else n_pass++;
    n_total++; if (bus.predict_valid !== 1'b0) $display("FAIL init_exit_pv: got %b want 0", bus.predict_valid); else n_pass++;
    lookup(32'h100, rdy, pv, pt);
    n_total++; if (rdy !== 1'b1) $display("FAIL first_lr: got %b want 1", rdy); else n_pass++;
    n_total++; if (pv !== 1'b1) $display("FAIL first_pv: got %b want 1", pv); else n_pass++;
    n_total++; if (pt !== 1'b0) $display("FAIL first_pt: got %b want 0", pt); else n_pass++;
    step(); step(); step();
    lookup(32'h40, rdy, pv, pt);
    n_total++; if (pt !== 1'b0) $display("FAIL init_no_push: got %b want 0", pt); else n_pass++;
  endtask

  task automatic test_saturation();
    logic rdy, pv, pt;
    update(32'h40, 1'b1); update(32'h40, 1'b1); update(32'h40, 1'b1);
    lookup(32'h40, rdy, pv, pt);
    n_total++; if (pt !== 1'b1) $display("FAIL sat_up: got %b want 1", pt); else n_pass++;
    update(32'h40, 1'b1); update(32'h40, 1'b0);
    lookup(32'h40, rdy, pv, pt);
    n_total++; if (pt !== 1'b1) $display("FAIL sat_hold_10: got %b want 1", pt); else n_pass++;
    update(32'h40, 1'b0);
    lookup(32'h40, rdy, pv, pt);
    n_total++; if (pt !== 1'b0) $display("FAIL sat_01: got %b want 0", pt); else n_pass++;
    update(32'h40, 1'b0);
    lookup(32'h40, rdy, pv, pt);
    n_total++; if (pt !== 1'b0) $display("FAIL sat_00: got %b want 0", pt); else n_pass++;
    // From 00 one taken step must give 01 (still not-taken) if floor held.
    update(32'h40, 1'b0); update(32'h40, 1'b1);
    lookup(32'h40, rdy, pv, pt);
    n_total++; if (pt !== 1'b0) $display("FAIL sat_floor: got %b want 0", pt); else n_pass++;
  endtask

  task automatic test_alias();
    logic rdy, pv, pt;
    update(32'h0, 1'b1); update(32'h100, 1'b1);
    lookup(32'h0, rdy, pv, pt);
    n_total++; if (pt !== 1'b1) $display("FAIL alias_pc0: got %b want 1", pt); else n_pass++;
    lookup(32'h100, rdy, pv, pt);
    n_total++; if (pt !== 1'b1) $display("FAIL alias_pc100: got %b want 1", pt); else n_pass++;
    update(32'h100, 1'b0); update(32'h0, 1'b0);
    lookup(32'h0, rdy, pv, pt);
    n_total++; if (pt !== 1'b0) $display("FAIL alias_down: got %b want 0", pt); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit [0:7] exp_ur = 8'b1111_0010;
    bit [0:7] exp_lr = 8'b1111_1011;
    int   acc = 0;
    logic rdy, pv, pt;
    bus.lookup_valid = 1'b1; bus.lookup_pc = 32'h10;
    bus.update_valid = 1'b1; bus.update_pc = 32'hC0; bus.update_taken = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      n_total++; if (bus.update_ready !== exp_ur[i]) $display("FAIL bp_ur[%0d]: got %b want %b", i, bus.update_ready, exp_ur[i]); else n_pass++;
      n_total++; if (bus.lookup_ready !== exp_lr[i]) $display("FAIL bp_lr[%0d]: got %b want %b", i, bus.lookup_ready, exp_lr[i]); else n_pass++;
      if (i == 5) begin
        n_total++; if (bus.predict_valid !== 1'b1) $display("FAIL bp_pv5: got %b want 1", bus.predict_valid); else n_pass++;
      end
      if (i == 6) begin
        n_total++; if (bus.predict_valid !== 1'b0) $display("FAIL bp_pv6: got %b want 0", bus.predict_valid); else n_pass++;
      end
      if (bus.update_ready === 1'b1) acc++;
      if (i < 7) step();
    end
    bus.lookup_valid = 1'b0; bus.update_valid = 1'b0;
    n_total++; if (acc !== 5) $display("FAIL bp_pushes: got %0d want 5", acc); else n_pass++;
    for (int i = 0; i < 6; i++) step();
    lookup(32'hC0, rdy, pv, pt);
    n_total++; if (pt !== 1'b1) $display("FAIL bp_drain_taken: got %b want 1", pt); else n_pass++;
    update(32'hC0, 1'b0);
    lookup(32'hC0, rdy, pv, pt);
    n_total++; if (pt !== 1'b1) $display("FAIL bp_drain_sat: got %b want 1", pt); else n_pass++;
  endtask

  task automatic test_mid_reset();
    int   cnt;
    logic rdy, pv, pt;
    update(32'h20, 1'b1); update(32'h20, 1'b1);
    bus.lookup_valid = 1'b1; bus.lookup_pc = 32'h20;
    bus.update_valid = 1'b1; bus.update_pc = 32'h20; bus.update_taken = 1'b1;
    step(); step(); step();
    bus.update_valid = 1'b0;
    n_total++; if (bus.predict_taken !== 1'b1) $display("FAIL mr_pre_pt: got %b want 1", bus.predict_taken); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (bus.predict_valid !== 1'b0) $display("FAIL mr_pv: got %b want 0", bus.predict_valid); else n_pass++;
    n_total++; if (bus.predict_taken !== 1'b0) $display("FAIL mr_pt: got %b want 0", bus.predict_taken); else n_pass++;
    n_total++; if (bus.init_busy !== 1'b1) $display("FAIL mr_busy: got %b want 1", bus.init_busy); else n_pass++;
    n_total++; if (bus.lookup_ready !== 1'b0) $display("FAIL mr_lr: got %b want 0", bus.lookup_ready); else n_pass++;
    bus.lookup_valid = 1'b0;
    step();
    rst = 1'b0;
    cnt = 0;
    while (bus.init_busy === 1'b1 && cnt < 200) begin
      cnt++;
      step();
    end
    n_total++; if (cnt !== 64) $display("FAIL mr_init_len: got %0d want 64", cnt); else n_pass++;
    step(); step(); step();
    lookup(32'h20, rdy, pv, pt);
    n_total++; if (pt !== 1'b0) $display("FAIL mr_cleared: got %b want 0", pt); else n_pass++;
  endtask

  task automatic test_read_after_update();
    logic rdy, pv, pt;
    update(32'h80, 1'b1);
    lookup(32'h80, rdy, pv, pt);
    n_total++; if (rdy !== 1'b1) $display("FAIL rau_lr: got %b want 1", rdy); else n_pass++;
    n_total++; if (pv !== 1'b1) $display("FAIL rau_pv: got %b want 1", pv); else n_pass++;
    n_total++; if (pt !== 1'b1) $display("FAIL rau_pt: got %b want 1", pt); else n_pass++;
    step();
    n_total++; if (bus.predict_valid !== 1'b0) $display("FAIL rau_pv_drop: got %b want 0", bus.predict_valid); else n_pass++;
    n_total++; if (bus.predict_taken !== 1'b1) $display("FAIL rau_pt_hold: got %b want 1", bus.predict_taken); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_alias();
    test_backpressure();
    test_mid_reset();
    test_read_after_update();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
